// File: rtl/car_pkg.sv
// Encodings shared by the manual-drive controller and the UART command transmitter.
// Holds the drive/move codes, the command-byte layout and the TX FSM state type.
package car_pkg;

    localparam logic [1:0] NSTART = 2'b00;
    localparam logic [1:0] START  = 2'b01;
    localparam logic [1:0] MOVING = 2'b10;

    localparam logic [3:0] MOVE_NONE  = 4'b0000;
    localparam logic [3:0] MOVE_FWD   = 4'b0001;
    localparam logic [3:0] MOVE_BACK  = 4'b0010;
    localparam logic [3:0] MOVE_LEFT  = 4'b0100;
    localparam logic [3:0] MOVE_RIGHT = 4'b1000;

    localparam int CMD_POWER    = 7;
    localparam int CMD_LAMP     = 6;
    localparam int CMD_STATE_HI = 5;
    localparam int CMD_STATE_LO = 4;
    localparam int CMD_MOVE_HI  = 3;
    localparam int CMD_MOVE_LO  = 0;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Powered-off always maps to the all-zero command so the car sees a single safe code.
    function automatic logic [7:0] pack_cmd(input logic       power,
                                            input logic [1:0] state,
                                            input logic [3:0] moving_state,
                                            input logic       lamp);
        logic [7:0] cmd;
        cmd = 8'h00;
        if (power) begin
            cmd[CMD_POWER]                 = 1'b1;
            cmd[CMD_LAMP]                  = lamp;
            cmd[CMD_STATE_HI:CMD_STATE_LO] = state;
            cmd[CMD_MOVE_HI:CMD_MOVE_LO]   = moving_state;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/car_cmd_uart_tx_if.sv
// Bundle between the controller state registers and the UART command transmitter.
interface car_cmd_uart_tx_if;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic       left_light;
    logic       right_light;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [7:0] last_cmd;

    modport master (
        output power, state, moving_state, left_light, right_light,
        input  tx, busy, frame_done, last_cmd
    );

    modport slave (
        input  power, state, moving_state, left_light, right_light,
        output tx, busy, frame_done, last_cmd
    );
endinterface

// File: rtl/car_cmd_uart_tx_baud_gen.sv
// Bit-period counter: wraps every BAUD_DIV clocks, restartable so a frame begins on a full bit.
module uart_baud_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick     = (cnt_reg == CW'(BAUD_DIV - 1));
    // One clock early, so registered outputs can land on the last clock of a bit.
    assign pre_tick = (cnt_reg == CW'(BAUD_DIV - 2));

endmodule

// File: rtl/car_cmd_uart_tx.sv
// Packs the controller outputs into a command byte and sends it as 8N1 UART,
// on every command change and as a periodic heartbeat when nothing changes.
module car_cmd_uart_tx
    import car_pkg::*;
#(
    parameter int CLK_HZ           = 100_000_000,
    parameter int BAUD             = 9600,
    parameter int HEARTBEAT_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    car_cmd_uart_tx_if.slave    bus
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int HB_W     = (HEARTBEAT_CYCLES > 2) ? $clog2(HEARTBEAT_CYCLES) : 2;
    localparam logic [HB_W-1:0] HB_MAX = HB_W'(HEARTBEAT_CYCLES - 1);

    tx_state_e       state_reg,      state_next;
    logic [7:0]      shift_reg,      shift_next;
    logic [7:0]      last_cmd_reg,   last_cmd_next;
    logic [HB_W-1:0] hb_cnt_reg,     hb_cnt_next;
    logic [2:0]      bit_idx_reg,    bit_idx_next;
    logic            tx_reg,         tx_next;
    logic            busy_reg,       busy_next;
    logic            frame_done_reg, frame_done_next;

    logic [7:0] cmd_next;
    logic       start_frame;
    logic       tick;
    logic       pre_tick;

    assign cmd_next = pack_cmd(bus.power, bus.state, bus.moving_state,
                               bus.left_light | bus.right_light);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_frame),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= TX_IDLE;
            shift_reg      <= 8'h00;
            last_cmd_reg   <= 8'h00;
            hb_cnt_reg     <= '0;
            bit_idx_reg    <= 3'd0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            last_cmd_reg   <= last_cmd_next;
            hb_cnt_reg     <= hb_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            tx_reg         <= tx_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        last_cmd_next   = last_cmd_reg;
        hb_cnt_next     = (hb_cnt_reg == HB_MAX) ? hb_cnt_reg : hb_cnt_reg + HB_W'(1);
        bit_idx_next    = bit_idx_reg;
        tx_next         = tx_reg;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;
        start_frame     = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                // A change and heartbeat expiry on the same edge still yield a single frame.
                if ((cmd_next != last_cmd_reg) || (hb_cnt_reg == HB_MAX)) begin
                    start_frame   = 1'b1;
                    shift_next    = cmd_next;
                    last_cmd_next = cmd_next;
                    hb_cnt_next   = '0;
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                    state_next    = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_next      = shift_reg[0];
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = 3'd0;
                    state_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = TX_STOP;
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (pre_tick) begin
                    frame_done_next = 1'b1;
                end
                if (tick) begin
                    busy_next  = 1'b0;
                    state_next = TX_IDLE;
                end
            end
            default: begin
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                state_next = TX_IDLE;
            end
        endcase
    end

    assign bus.tx         = tx_reg;
    assign bus.busy       = busy_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.last_cmd   = last_cmd_reg;

endmodule

// File: tb/tb_car_cmd_uart_tx.sv
// Directed bench for car_cmd_uart_tx: a line monitor decodes frames against a queue of expected bytes.
module tb_car_cmd_uart_tx;
    import car_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int   checks = 0;
    int   errors = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         n_start = 0;
    int         n_done  = 0;
    int         n_abort = 0;

    car_cmd_uart_tx_if bus();

    car_cmd_uart_tx #(
        .CLK_HZ           (16),
        .BAUD             (1),
        .HEARTBEAT_CYCLES (400)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int st(input int i);
        if (i < start_q.size()) return start_q[i];
        return -100000;
    endfunction

    task automatic wait_start(input int target, input int budget);
        int n = 0;
        while (n_start < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_start", int'(n_start >= target), 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (n_done < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_done", int'(n_done >= target), 1);
    endtask

    // Line monitor: start detected at c=0, bits sampled mid-period, stop/frame_done at fixed offsets.
    initial begin
        logic [7:0] byte_v;
        int         exp_b;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst && bus.tx === 1'b0) begin
                aborted = 1'b0;
                byte_v  = 8'h00;
                exp_b   = (exp_q.size() > 0) ? int'(exp_q[0]) : -1;
                n_start++;
                start_q.push_back(cyc);
                check("start_busy", int'(bus.busy), 1);
                check("start_last_cmd", int'(bus.last_cmd), exp_b);
                for (int c = 1; c <= 160; c++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c == 8) check("start_bit", int'(bus.tx), 0);
                    if (c >= 24 && c <= 136 && ((c - 24) % 16) == 0)
                        byte_v[(c - 24) / 16] = bus.tx;
                    if (c == 152) check("stop_bit", int'(bus.tx), 1);
                    if (c == 158) check("frame_done_early", int'(bus.frame_done), 0);
                    if (c == 159) begin
                        check("frame_done_pulse", int'(bus.frame_done), 1);
                        check("busy_last_stop", int'(bus.busy), 1);
                    end
                    if (c == 160) begin
                        check("frame_done_clear", int'(bus.frame_done), 0);
                        check("busy_idle", int'(bus.busy), 0);
                    end
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (aborted) begin
                    n_abort++;
                    $display("frame %0d aborted by reset at cycle %0d", n_start, cyc);
                end else begin
                    check("frame_byte", int'(byte_v), exp_b);
                    n_done++;
                    $display("frame %0d byte=0x%02h expected=0x%0h start=%0d", n_start, byte_v, exp_b, st(n_start - 1));
                end
            end
        end
    end

    initial begin
        int t_rel;
        int t_chg;
        bus.power        = 1'b0;
        bus.state        = NSTART;
        bus.moving_state = MOVE_NONE;
        bus.left_light   = 1'b0;
        bus.right_light  = 1'b0;

        // 1: reset state, then power-off heartbeat frame
        repeat (3) @(negedge clk);
        check("reset_tx", int'(bus.tx), 1);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_frame_done", int'(bus.frame_done), 0);
        check("reset_last_cmd", int'(bus.last_cmd), 0);
        exp_q.push_back(8'h00);
        rst   = 1'b1;
        t_rel = cyc;
        wait_start(1, 600);
        check("hb_first_start", st(0) - t_rel, 400);
        wait_done(1, 300);

        // 2: command change -> 0xA1, one-edge latency
        @(negedge clk);
        bus.power        = 1'b1;
        bus.state        = MOVING;
        bus.moving_state = MOVE_FWD;
        t_chg = cyc;
        exp_q.push_back(8'hA1);
        wait_start(2, 50);
        check("change_latency", st(1) - t_chg, 1);

        // 3: changes mid-frame; intermediate 0xA4 dropped, newest 0xE4 sent after one idle cycle
        repeat (70) @(negedge clk);
        bus.moving_state = MOVE_LEFT;
        repeat (32) @(negedge clk);
        bus.left_light = 1'b1;
        exp_q.push_back(8'hE4);
        wait_done(2, 200);
        wait_start(3, 50);
        check("one_idle_gap", st(2) - st(1), 161);

        // 4: constant inputs -> heartbeat repeats every 400 clocks
        exp_q.push_back(8'hE4);
        exp_q.push_back(8'hE4);
        wait_start(5, 1000);
        check("hb_period_1", st(3) - st(2), 400);
        check("hb_period_2", st(4) - st(3), 400);

        // 5: reset during data bit 5 aborts the frame immediately
        exp_q.push_back(8'hE4);
        wait_start(6, 500);
        repeat (104) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_tx", int'(bus.tx), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_last_cmd", int'(bus.last_cmd), 0);
        repeat (3) @(negedge clk);
        check("abort_seen", n_abort, 1);
        exp_q.push_back(8'hE4);
        rst = 1'b1;
        wait_start(7, 50);
        wait_done(6, 200);

        // 6: power off masks the other inputs
        @(negedge clk);
        bus.power = 1'b0;
        exp_q.push_back(8'h00);
        wait_start(8, 50);
        wait_done(7, 200);
        check("poweroff_last_cmd", int'(bus.last_cmd), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
